// File: rtl/el_call_scheduler.sv
// el_call_scheduler: request latching, position tracking and SCAN-style
// motion/door sequencing for a 3-floor elevator car.
module el_call_scheduler #(
    parameter int unsigned DOOR_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       F1,
    input  logic       F2,
    input  logic       F3,
    input  logic       U1,
    input  logic       U2,
    input  logic       D2,
    input  logic       D3,
    input  logic       U3,
    input  logic       D1,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    output logic [1:0] AC,
    output logic [1:0] DISP,
    output logic       open,
    output logic       DIR,
    output logic [2:0] PEND
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DOOR = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(DOOR_CYCLES - 1);

    // One-hot mask (bit n = floor n) for an encoded floor number 1..3.
    function automatic logic [3:1] floor_mask(input logic [1:0] f);
        return {f == 2'd3, f == 2'd2, f == 2'd1};
    endfunction

    // Floors strictly above the floor selected by a one-hot mask.
    function automatic logic [3:1] above_mask(input logic [3:1] m);
        return {m[2] | m[1], m[1], 1'b0};
    endfunction

    // Floors strictly below the floor selected by a one-hot mask.
    function automatic logic [3:1] below_mask(input logic [3:1] m);
        return {1'b0, m[3], m[3] | m[2]};
    endfunction

    state_t     state_q, state_d;
    logic [1:0] cur_floor_q, cur_floor_d;
    logic       dir_q, dir_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:1] car_req_q, car_req_d;
    logic [2:1] up_req_q, up_req_d;
    logic [3:2] dn_req_q, dn_req_d;
    logic [1:0] ac_q, ac_d;
    logic       open_q, open_d;
    logic [2:0] pend_q, pend_d;

    // U3 and D1 exist only for pin compatibility.
    logic unused_pins;
    assign unused_pins = U3 ^ D1;

    logic [3:1] sens_v;
    logic       sens_ok;
    logic [1:0] sens_floor;
    logic [3:1] up_v;
    logic [3:1] dn_v;
    logic [3:1] pend_v;
    logic [3:1] cur_m;

    // Sensor decode and per-floor views of the request latches.
    always_comb begin
        sens_v     = {S3, S2, S1};
        sens_ok    = $onehot(sens_v);
        sens_floor = S3 ? 2'd3 : (S2 ? 2'd2 : 2'd1);
        up_v       = {1'b0, up_req_q};
        dn_v       = {dn_req_q, 1'b0};
        pend_v     = car_req_q | up_v | dn_v;
        cur_m      = floor_mask(cur_floor_q);
    end

    logic [3:1] car_set;
    logic [2:1] up_set;
    logic [3:2] dn_set;
    logic [3:1] car_clr;
    logic [2:1] up_clr;
    logic [3:2] dn_clr;
    logic       reload;
    logic       door_go;
    logic [3:1] door_m;
    logic       beyond;
    logic       fwd_cur;
    logic       rev_cur;
    logic       serve_here;

    // Next-state, request set/clear arbitration and registered-output values.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        cur_floor_d = sens_ok ? sens_floor : cur_floor_q;
        car_set     = {F3, F2, F1};
        up_set      = {U2, U1};
        dn_set      = {D3, D2};
        car_clr     = '0;
        up_clr      = '0;
        dn_clr      = '0;
        reload      = 1'b0;
        door_go     = 1'b0;
        door_m      = cur_m;
        beyond      = 1'b0;

        // Requests ahead of / behind the car in its current preference.
        fwd_cur = dir_q ? |(pend_v & above_mask(cur_m)) : |(pend_v & below_mask(cur_m));
        rev_cur = dir_q ? |(pend_v & below_mask(cur_m)) : |(pend_v & above_mask(cur_m));

        // Only requests that a stop here would actually clear count as
        // "at this floor"; an opposite hall call with work still ahead
        // would otherwise reopen the door forever.
        serve_here = |(cur_m & car_req_q)
                   | |(cur_m & (dir_q ? up_v : dn_v))
                   | (|(cur_m & (dir_q ? dn_v : up_v)) & ~fwd_cur);

        // While the door is open, presses for this floor extend it instead
        // of being latched.
        if (state_q == S_DOOR) begin
            reload  = |(car_set & cur_m)
                    | (dir_q ? |(up_set & cur_m[2:1]) : |(dn_set & cur_m[3:2]));
            car_set = car_set & ~cur_m;
            if (dir_q) begin
                up_set = up_set & ~cur_m[2:1];
            end else begin
                dn_set = dn_set & ~cur_m[3:2];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (serve_here) begin
                    door_go = 1'b1;
                end else if (fwd_cur) begin
                    state_d = dir_q ? S_UP : S_DOWN;
                end else if (rev_cur) begin
                    dir_d   = ~dir_q;
                    state_d = dir_q ? S_DOWN : S_UP;
                end
            end
            S_UP: begin
                if (sens_ok) begin
                    door_m = sens_v;
                    if (sens_v[3] || |(sens_v & (car_req_q | up_v))
                        || !(|(pend_v & above_mask(sens_v)))) begin
                        door_go = 1'b1;
                    end
                end
            end
            S_DOWN: begin
                if (sens_ok) begin
                    door_m = sens_v;
                    if (sens_v[1] || |(sens_v & (car_req_q | dn_v))
                        || !(|(pend_v & below_mask(sens_v)))) begin
                        door_go = 1'b1;
                    end
                end
            end
            S_DOOR: begin
                if (reload) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Door entry: serve this floor, and turn around if nothing lies ahead.
        if (door_go) begin
            state_d = S_DOOR;
            cnt_d   = CNT_LOAD;
            car_clr = door_m;
            beyond  = dir_q ? |(pend_v & above_mask(door_m)) : |(pend_v & below_mask(door_m));
            if (dir_q) begin
                up_clr = door_m[2:1];
            end else begin
                dn_clr = door_m[3:2];
            end
            if (!beyond) begin
                if (dir_q) begin
                    dn_clr = door_m[3:2];
                end else begin
                    up_clr = door_m[2:1];
                end
                dir_d = ~dir_q;
            end
        end

        // Clear beats a simultaneous set on the same bit.
        car_req_d = (car_req_q | car_set) & ~car_clr;
        up_req_d  = (up_req_q | up_set) & ~up_clr;
        dn_req_d  = (dn_req_q | dn_set) & ~dn_clr;

        pend_d = car_req_d | {1'b0, up_req_d} | {dn_req_d, 1'b0};
        ac_d   = (state_d == S_UP) ? 2'b01 : ((state_d == S_DOWN) ? 2'b10 : 2'b00);
        open_d = (state_d == S_DOOR);
    end

    // Sequencer state, request latches and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cur_floor_q <= 2'd1;
            dir_q       <= 1'b1;
            cnt_q       <= 4'd0;
            car_req_q   <= '0;
            up_req_q    <= '0;
            dn_req_q    <= '0;
            ac_q        <= 2'b00;
            open_q      <= 1'b0;
            pend_q      <= 3'b000;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            car_req_q   <= car_req_d;
            up_req_q    <= up_req_d;
            dn_req_q    <= dn_req_d;
            ac_q        <= ac_d;
            open_q      <= open_d;
            pend_q      <= pend_d;
        end
    end

    assign AC   = ac_q;
    assign DISP = cur_floor_q;
    assign open = open_q;
    assign DIR  = dir_q;
    assign PEND = pend_q;

endmodule

// File: tb/tb_el_call_scheduler.sv
// Directed bench for el_call_scheduler (DOOR_CYCLES = 4). Scenarios run back
// to back; each starts from the car position the previous one left behind.
module tb_el_call_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       F1 = 0, F2 = 0, F3 = 0;
    logic       U1 = 0, U2 = 0, D2 = 0, D3 = 0, U3 = 0, D1 = 0;
    logic       S1 = 1, S2 = 0, S3 = 0;
    logic [1:0] AC;
    logic [1:0] DISP;
    logic       open_w;
    logic       DIR;
    logic [2:0] PEND;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    el_call_scheduler #(.DOOR_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST),
        .F1(F1), .F2(F2), .F3(F3),
        .U1(U1), .U2(U2), .D2(D2), .D3(D3), .U3(U3), .D1(D1),
        .S1(S1), .S2(S2), .S3(S3),
        .AC(AC), .DISP(DISP), .open(open_w), .DIR(DIR), .PEND(PEND)
    );

    // Advance one clock; sample 1 ns after the edge. AC=11 must never appear.
    task automatic tick();
        @(posedge CLK);
        #1;
        n_cmp++; if (AC === 2'b11) begin n_bad++; $display("FAIL ac_never_11 got AC=%b, must not be 11", AC); end
    endtask

    task automatic test_reset();
        RST = 1'b1; S1 = 1'b1;
        tick(); tick();
        RST = 1'b0;
        n_cmp++; if (AC !== 2'b00) begin n_bad++; $display("FAIL rst_ac got %b exp 00", AC); end
        n_cmp++; if (DISP !== 2'b01) begin n_bad++; $display("FAIL rst_disp got %b exp 01", DISP); end
        n_cmp++; if (open_w !== 1'b0) begin n_bad++; $display("FAIL rst_open got %b exp 0", open_w); end
        n_cmp++; if (PEND !== 3'b000) begin n_bad++; $display("FAIL rst_pend got %b exp 000", PEND); end
        n_cmp++; if (DIR !== 1'b1) begin n_bad++; $display("FAIL rst_dir got %b exp 1", DIR); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (AC !== 2'b00) begin n_bad++; $display("FAIL idle_ac[%0d] got %b exp 00", i, AC); end
            n_cmp++; if (open_w !== 1'b0) begin n_bad++; $display("FAIL idle_open[%0d] got %b exp 0", i, open_w); end
            n_cmp++; if (PEND !== 3'b000) begin n_bad++; $display("FAIL idle_pend[%0d] got %b exp 000", i, PEND); end
        end
    endtask

    task automatic test_single_call();
        F3 = 1'b1; tick(); F3 = 1'b0;
        n_cmp++; if (PEND !== 3'b100) begin n_bad++; $display("FAIL single_pend got %b exp 100", PEND); end
        n_cmp++; if (AC !== 2'b00) begin n_bad++; $display("FAIL single_ac_latch got %b exp 00", AC); end
        tick();
        n_cmp++; if (AC !== 2'b01) begin n_bad++; $display("FAIL single_ac_start got %b exp 01", AC); end
        S1 = 1'b0; tick();
        n_cmp++; if (AC !== 2'b01) begin n_bad++; $display("FAIL single_ac_gap got %b exp 01", AC); end
        S2 = 1'b1; tick();
        n_cmp++; if (AC !== 2'b01) begin n_bad++; $display("FAIL single_pass2_ac got %b exp 01", AC); end
        n_cmp++; if (DISP !== 2'b10) begin n_bad++; $display("FAIL single_pass2_disp got %b exp 10", DISP); end
        S2 = 1'b0; tick();
        S3 = 1'b1; tick();
        n_cmp++; if (AC !== 2'b00) begin n_bad++; $display("FAIL single_stop3_ac got %b exp 00", AC); end
        n_cmp++; if (open_w !== 1'b1) begin n_bad++; $display("FAIL single_stop3_open got %b exp 1", open_w); end
        n_cmp++; if (DISP !== 2'b11) begin n_bad++; $display("FAIL single_stop3_disp got %b exp 11", DISP); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (open_w !== 1'b1) begin n_bad++; $display("FAIL single_door_open[%0d] got %b exp 1", i, open_w); end
        end
        tick();
        n_cmp++; if (open_w !== 1'b0) begin n_bad++; $display("FAIL single_door_close got %b exp 0", open_w); end
        n_cmp++; if (PEND !== 3'b000) begin n_bad++; $display("FAIL single_pend_done got %b exp 000", PEND); end
        n_cmp++; if (DIR !== 1'b0) begin n_bad++; $display("FAIL single_dir_flip got %b exp 0", DIR); end
        tick();
        n_cmp++; if (AC !== 2'b00) begin n_bad++; $display("FAIL single_idle_ac got %b exp 00", AC); end
    endtask

    task automatic test_scan();
        S3 = 1'b0; S1 = 1'b1; RST = 1'b1; tick(); RST = 1'b0;
        F3 = 1'b1; tick(); F3 = 1'b0; tick();
        n_cmp++; if (AC !== 2'b01) begin n_bad++; $display("FAIL scan_up_start got %b exp 01", AC); end
        S1 = 1'b0; D2 = 1'b1; tick(); D2 = 1'b0;
        n_cmp++; if (PEND !== 3'b110) begin n_bad++; $display("FAIL scan_pend_d2 got %b exp 110", PEND); end
        S2 = 1'b1; tick();
        n_cmp++; if (AC !== 2'b01) begin n_bad++; $display("FAIL scan_pass2_ac got %b exp 01", AC); end
        n_cmp++; if (DISP !== 2'b10) begin n_bad++; $display("FAIL scan_pass2_disp got %b exp 10", DISP); end
        S2 = 1'b0; tick();
        S3 = 1'b1; tick();
        n_cmp++; if (open_w !== 1'b1) begin n_bad++; $display("FAIL scan_stop3_open got %b exp 1", open_w); end
        n_cmp++; if (PEND !== 3'b010) begin n_bad++; $display("FAIL scan_stop3_pend got %b exp 010", PEND); end
        n_cmp++; if (DIR !== 1'b0) begin n_bad++; $display("FAIL scan_stop3_dir got %b exp 0", DIR); end
        U2 = 1'b1; F1 = 1'b1; tick(); U2 = 1'b0; F1 = 1'b0;
        n_cmp++; if (PEND !== 3'b011) begin n_bad++; $display("FAIL scan_pend_u2f1 got %b exp 011", PEND); end
        tick(); tick(); tick();
        n_cmp++; if (open_w !== 1'b0) begin n_bad++; $display("FAIL scan_door3_close got %b exp 0", open_w); end
        tick();
        n_cmp++; if (AC !== 2'b10) begin n_bad++; $display("FAIL scan_down_start got %b exp 10", AC); end
        S3 = 1'b0; tick();
        S2 = 1'b1; tick();
        n_cmp++; if (AC !== 2'b00) begin n_bad++; $display("FAIL scan_stop2_ac got %b exp 00", AC); end
        n_cmp++; if (open_w !== 1'b1) begin n_bad++; $display("FAIL scan_stop2_open got %b exp 1", open_w); end
        n_cmp++; if (PEND !== 3'b011) begin n_bad++; $display("FAIL scan_stop2_pend got %b exp 011", PEND); end
        n_cmp++; if (DIR !== 1'b0) begin n_bad++; $display("FAIL scan_stop2_dir got %b exp 0", DIR); end
        tick(); tick(); tick(); tick();
        n_cmp++; if (open_w !== 1'b0) begin n_bad++; $display("FAIL scan_door2_close got %b exp 0", open_w); end
        tick();
        n_cmp++; if (AC !== 2'b10) begin n_bad++; $display("FAIL scan_leave2_ac got %b exp 10", AC); end
        S2 = 1'b0; tick();
        S1 = 1'b1; tick();
        n_cmp++; if (open_w !== 1'b1) begin n_bad++; $display("FAIL scan_stop1_open got %b exp 1", open_w); end
        n_cmp++; if (PEND !== 3'b010) begin n_bad++; $display("FAIL scan_stop1_pend got %b exp 010", PEND); end
        n_cmp++; if (DIR !== 1'b1) begin n_bad++; $display("FAIL scan_stop1_dir got %b exp 1", DIR); end
        n_cmp++; if (DISP !== 2'b01) begin n_bad++; $display("FAIL scan_stop1_disp got %b exp 01", DISP); end
        tick(); tick(); tick(); tick(); tick();
        n_cmp++; if (AC !== 2'b01) begin n_bad++; $display("FAIL scan_up_again got %b exp 01", AC); end
        S1 = 1'b0; tick();
        S2 = 1'b1; tick();
        n_cmp++; if (open_w !== 1'b1) begin n_bad++; $display("FAIL scan_u2_open got %b exp 1", open_w); end
        n_cmp++; if (PEND !== 3'b000) begin n_bad++; $display("FAIL scan_u2_pend got %b exp 000", PEND); end
        n_cmp++; if (DIR !== 1'b0) begin n_bad++; $display("FAIL scan_u2_dir got %b exp 0", DIR); end
    endtask

    // Continues in the door cycle at floor 2 that test_scan just opened.
    task automatic test_door_extend();
        tick(); tick();
        F2 = 1'b1; tick(); F2 = 1'b0;
        n_cmp++; if (open_w !== 1'b1) begin n_bad++; $display("FAIL ext_open_reload got %b exp 1", open_w); end
        n_cmp++; if (PEND !== 3'b000) begin n_bad++; $display("FAIL ext_pend_nolatch got %b exp 000", PEND); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (open_w !== 1'b1) begin n_bad++; $display("FAIL ext_open_hold[%0d] got %b exp 1", i, open_w); end
        end
        tick();
        n_cmp++; if (open_w !== 1'b0) begin n_bad++; $display("FAIL ext_close got %b exp 0", open_w); end
        tick();
        n_cmp++; if (open_w !== 1'b0) begin n_bad++; $display("FAIL ext_stay_closed got %b exp 0", open_w); end
        n_cmp++; if (AC !== 2'b00) begin n_bad++; $display("FAIL ext_idle_ac got %b exp 00", AC); end
    endtask

    task automatic test_reset_mid();
        F3 = 1'b1; tick(); F3 = 1'b0;
        n_cmp++; if (PEND !== 3'b100) begin n_bad++; $display("FAIL mid_pend got %b exp 100", PEND); end
        tick();
        n_cmp++; if (AC !== 2'b01) begin n_bad++; $display("FAIL mid_up got %b exp 01", AC); end
        n_cmp++; if (DIR !== 1'b1) begin n_bad++; $display("FAIL mid_dir_up got %b exp 1", DIR); end
        S2 = 1'b0; tick();
        RST = 1'b1; tick(); RST = 1'b0;
        n_cmp++; if (AC !== 2'b00) begin n_bad++; $display("FAIL mid_rst_ac got %b exp 00", AC); end
        n_cmp++; if (PEND !== 3'b000) begin n_bad++; $display("FAIL mid_rst_pend got %b exp 000", PEND); end
        n_cmp++; if (DISP !== 2'b01) begin n_bad++; $display("FAIL mid_rst_disp got %b exp 01", DISP); end
        n_cmp++; if (DIR !== 1'b1) begin n_bad++; $display("FAIL mid_rst_dir got %b exp 1", DIR); end
        tick();
        n_cmp++; if (AC !== 2'b00) begin n_bad++; $display("FAIL mid_after_ac got %b exp 00", AC); end
        S3 = 1'b1; tick();
        n_cmp++; if (DISP !== 2'b11) begin n_bad++; $display("FAIL mid_sensor_disp got %b exp 11", DISP); end
    endtask

    task automatic test_invalid_sensors();
        F1 = 1'b1; tick(); F1 = 1'b0; tick();
        n_cmp++; if (AC !== 2'b10) begin n_bad++; $display("FAIL inv_down got %b exp 10", AC); end
        n_cmp++; if (DIR !== 1'b0) begin n_bad++; $display("FAIL inv_dir got %b exp 0", DIR); end
        S3 = 1'b0; S2 = 1'b1; S1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (AC !== 2'b10) begin n_bad++; $display("FAIL inv_multi_ac[%0d] got %b exp 10", i, AC); end
            n_cmp++; if (DISP !== 2'b11) begin n_bad++; $display("FAIL inv_multi_disp[%0d] got %b exp 11", i, DISP); end
        end
        S2 = 1'b0; tick();
        n_cmp++; if (open_w !== 1'b1) begin n_bad++; $display("FAIL inv_stop1_open got %b exp 1", open_w); end
        n_cmp++; if (DISP !== 2'b01) begin n_bad++; $display("FAIL inv_stop1_disp got %b exp 01", DISP); end
        n_cmp++; if (PEND !== 3'b000) begin n_bad++; $display("FAIL inv_stop1_pend got %b exp 000", PEND); end
        tick(); tick(); tick(); tick();
        n_cmp++; if (open_w !== 1'b0) begin n_bad++; $display("FAIL inv_close got %b exp 0", open_w); end
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_scan();
        test_door_extend();
        test_reset_mid();
        test_invalid_sensors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
